sincos_arbiter: RTL
===================

Name: sincos_arbiter

Overview:
- Shares one sincos core between two phase requesters: requester 0 is the test-tone NCO, requester 1 is the mixer/LO NCO for the low-pass FIR bench.
- Arbitrates round-robin and normalises each phase into the core's [-pi, +pi] range.
- Issues to the core, then routes each core result back to the requester that issued it, using an in-flight tag FIFO.
- The core has no backpressure, so the block limits how many requests are outstanding.

Parameters:
- PHASE_W, 16, phase width; signed Q3.13 radians.
- OUT_W, 16, sin/cos width; signed Q1.14.
- TAG_DEPTH, 8, maximum in-flight requests; power of 2, at least 2.
- PI_Q, 16'sh6488, +pi in Q3.13 (25736). -pi = -PI_Q = 16'sh9B78.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_phase  in  PHASE_W  requester 0 phase.
- req0_valid  in  1  requester 0 request.
- req0_ready  out  1  requester 0 accept.
- req1_phase  in  PHASE_W  requester 1 phase.
- req1_valid  in  1  requester 1 request.
- req1_ready  out  1  requester 1 accept.
- core_phase  out  PHASE_W  phase to the sincos core.
- core_phase_tvalid  out  1  core input valid.
- core_cos  in  OUT_W  core cosine.
- core_sin  in  OUT_W  core sine.
- core_tvalid  in  1  core output valid.
- rsp0_cos  out  OUT_W  result to requester 0.
- rsp0_sin  out  OUT_W  result to requester 0.
- rsp0_valid  out  1  one-cycle pulse.
- rsp1_cos  out  OUT_W  result to requester 1.
- rsp1_sin  out  OUT_W  result to requester 1.
- rsp1_valid  out  1  one-cycle pulse.
- busy  out  1  at least one request in flight.
- err_orphan  out  1  sticky; core_tvalid seen while no request was in flight.

Behaviour:
- Reset (synchronous, active-high): all outputs 0. Tag FIFO emptied, in-flight count = 0, RR pointer = 0 (requester 0 wins the first tie).
- Handshake: a transfer occurs on reqN_valid & reqN_ready at a rising edge.
  - reqN_valid, once high, must hold with phase stable until accepted.
  - reqN_ready is combinational from registered state and the valids.
- Arbitration:
  - Only one request is granted per cycle, and only when count < TAG_DEPTH. Count is the registered value; a same-cycle pop does not free a slot.
  - Only one valid requester: it is granted.
  - Both valid: grant goes to the requester other than the last granted.
  - The RR pointer updates only on a transfer.
- Normalisation (17-bit signed intermediate p):
  - p > PI_Q: issue p - 2*PI_Q.
  - p < -PI_Q: issue p + 2*PI_Q.
  - Otherwise issue p unchanged; boundaries ±PI_Q pass through unchanged.
  - Example: 16'sh7000 (28672) is issued as -22800 (16'shA6F0).
- Issue latency: core_phase and core_phase_tvalid are registered, 1 cycle after the transfer. core_phase_tvalid is a single-cycle pulse per transfer; back-to-back transfers give consecutive pulses.
- Tag FIFO:
  - Depth TAG_DEPTH, 1-bit requester ID, pushed on each transfer.
  - Popped on each core_tvalid while count > 0.
  - Simultaneous push and pop: count unchanged, FIFO order preserved.
- Response routing:
  - Registered, 1 cycle after core_tvalid. The rspN_cos/sin of the popped ID load core_cos/core_sin, and rspN_valid pulses for 1 cycle.
  - The non-addressed rsp outputs hold their last values with valid = 0.
  - Results return in issue order. The core is in-order with fixed latency.
- Orphan result:
  - core_tvalid with count == 0 sets err_orphan (cleared only by rst).
  - No pop, no rsp pulse, the result is dropped.
  - This covers results still draining from the core after a mid-operation rst.
- busy = (count != 0), registered.
- Full (count == TAG_DEPTH): both ready = 0. Valids are held and not lost.

Test Plan:
- Single request: req0 phase 0 -> core_phase 0 with tvalid one cycle after the transfer. Core returns cos 16384, sin 0 -> rsp0_valid pulse 1 cycle later with cos 16384, sin 0; rsp1_valid stays 0.
- Contention: both valid every cycle, phases 256*k -> grants alternate 0,1,0,1 starting with 0. Responses arrive on the matching rsp port in issue order, and the per-requester sequences are monotonic.
- Wrap-around: req1 phase 16'sh6500 (25856) -> core_phase -25616. Phase 16'sh9B00 -> 25616. Phase 25736 -> 25736 unchanged.
- Full/backpressure: hold core_tvalid low, req0 valid continuously -> exactly 8 transfers, then req0_ready = 0 and busy = 1. One core_tvalid frees one slot, and ready returns the cycle after the pop.
- Simultaneous push/pop at count 8: ready stays 0 in the pop cycle and a transfer occurs the next cycle. Count never exceeds 8, and tag order is preserved.
- Mid-operation rst with 3 in flight -> all outputs 0. The 3 stale core_tvalid pulses after reset set err_orphan = 1 with no rsp pulses. A new request then completes normally.

Source files
------------

// File: rtl/sincos_arbiter.sv
// sincos_arbiter: round-robin sharing of one sincos core between two phase requesters with tag-routed results
module sincos_arbiter #(
  parameter int PHASE_W = 16,
  parameter int OUT_W = 16,
  parameter int TAG_DEPTH = 8,
  parameter logic signed [PHASE_W-1:0] PI_Q = 16'sh6488
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] req0_phase,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [PHASE_W-1:0] req1_phase,
  input  logic               req1_valid,
  output logic               req1_ready,
  output logic [PHASE_W-1:0] core_phase,
  output logic               core_phase_tvalid,
  input  logic [OUT_W-1:0]   core_cos,
  input  logic [OUT_W-1:0]   core_sin,
  input  logic               core_tvalid,
  output logic [OUT_W-1:0]   rsp0_cos,
  output logic [OUT_W-1:0]   rsp0_sin,
  output logic               rsp0_valid,
  output logic [OUT_W-1:0]   rsp1_cos,
  output logic [OUT_W-1:0]   rsp1_sin,
  output logic               rsp1_valid,
  output logic               busy,
  output logic               err_orphan
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic signed [PHASE_W:0] PI_X = {PI_Q[PHASE_W-1], PI_Q};
  localparam logic signed [PHASE_W:0] TWO_PI = PI_X <<< 1;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, rd_q;
  logic tag_q [TAG_DEPTH];
  logic prio_q, room, gnt0, gnt1, push, pop, id;
  logic [PHASE_W-1:0] ph;
  logic signed [PHASE_W:0] p, n;
  always_comb begin
    room = cnt_q != (AW+1)'(TAG_DEPTH);
    gnt0 = room & req0_valid & (~req1_valid | ~prio_q);
    gnt1 = room & req1_valid & (~req0_valid | prio_q);
    push = gnt0 | gnt1;
    pop = core_tvalid & (cnt_q != '0);
    id = tag_q[rd_q];
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ph = gnt1 ? req1_phase : req0_phase;
    p = $signed({ph[PHASE_W-1], ph});
    n = p > PI_X ? p - TWO_PI : p < -PI_X ? p + TWO_PI : p;
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy = cnt_q != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      prio_q <= 1'b0;
      core_phase <= '0;
      core_phase_tvalid <= 1'b0;
      rsp0_cos <= '0;
      rsp0_sin <= '0;
      rsp0_valid <= 1'b0;
      rsp1_cos <= '0;
      rsp1_sin <= '0;
      rsp1_valid <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      core_phase_tvalid <= push;
      rsp0_valid <= pop & ~id;
      rsp1_valid <= pop & id;
      err_orphan <= err_orphan | (core_tvalid & (cnt_q == '0));
      if (push) begin
        tag_q[wr_q] <= gnt1;
        wr_q <= wr_q + 1'b1;
        prio_q <= gnt0;
        core_phase <= n[PHASE_W-1:0];
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (pop & ~id) begin
        rsp0_cos <= core_cos;
        rsp0_sin <= core_sin;
      end
      if (pop & id) begin
        rsp1_cos <= core_cos;
        rsp1_sin <= core_sin;
      end
    end
  end
endmodule
